counter_seq_checker: RTL and testbench

COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

---
 rtl/counter_seq_checker.sv | 202 ++++++++++++++++++++
 tb/tb_counter_seq_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// ---------------------------------------------------------------------------
// counter_seq_checker
//
// Watches the 4-bit output of a slow counter under test and checks that it
// steps through the expected sequence: a 4-bit down counter (mode 0) or a
// 4-bit Johnson counter (mode 1). Both the sample strobe and the observed
// value are brought into the clk domain through 2-flop synchronizers. A
// sample is taken on the falling edge of the synchronized strobe, i.e.
// mid-period of the counter under test, away from its update edge.
//
// The FSM (IDLE -> TRACK -> LOCKED) has to see LOCK_COUNT consecutive
// correct steps before it trusts the sequence. Once LOCKED, any wrong step
// is recorded in the sticky error outputs, and the FSM falls back to TRACK
// to resynchronize on the bad value.
//
// Ports
//   clk       system clock, rising-edge active
//   rst       asynchronous reset, active-low
//   tick      slow sample strobe (asynchronous)
//   bit_in    observed counter value (asynchronous)
//   mode      0 = down counter, 1 = Johnson counter (latched while idle)
//   clr       synchronous clear of err / err_cnt / last_bad, active-high
//   locked    high while the FSM is in LOCKED
//   err       sticky mismatch flag (mismatches seen in LOCKED only)
//   err_cnt   saturating mismatch count (mismatches seen in LOCKED only)
//   last_bad  most recent mismatching sample seen in LOCKED
// ---------------------------------------------------------------------------
module counter_seq_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [3:0]       bit_in,
    input  logic             mode,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       last_bad
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic johnson_legal(input logic [3:0] v);
        logic ok;
        case (v)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next value the counter under test should show after p.
    function automatic logic [3:0] expected_next(input logic [3:0] p,
                                                 input logic       m);
        return m ? {p[2:0], ~p[3]} : (p - 4'd1);
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : (c + ERR_W'(1));
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers: _p0/_p1 are the two sync flops, tick_p2 holds the
    // previous synchronized strobe for edge detection.
    // ------------------------------------------------------------------
    logic       tick_p0, tick_p1, tick_p2;
    logic [3:0] bit_p0, bit_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_p0 <= 1'b0;
            tick_p1 <= 1'b0;
            tick_p2 <= 1'b0;
            bit_p0  <= 4'd0;
            bit_p1  <= 4'd0;
        end else begin
            tick_p0 <= tick;
            tick_p1 <= tick_p0;
            tick_p2 <= tick_p1;
            bit_p0  <= bit_in;
            bit_p1  <= bit_p0;
        end
    end

    logic sample_evt;
    assign sample_evt = tick_p2 & ~tick_p1;

    // ------------------------------------------------------------------
    // FSM and checker state
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic             mode_r, mode_nxt;
    logic [3:0]       prev, prev_nxt;
    logic [3:0]       match_cnt, cnt_nxt;
    logic             err_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic [3:0]       last_bad_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            prev      <= 4'd0;
            match_cnt <= 4'd0;
            err       <= 1'b0;
            err_cnt   <= '0;
            last_bad  <= 4'd0;
        end else begin
            state     <= state_nxt;
            mode_r    <= mode_nxt;
            prev      <= prev_nxt;
            match_cnt <= cnt_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            last_bad  <= last_bad_nxt;
        end
    end

    // In Johnson mode an illegal code never counts as a match, even when it
    // equals the shifted previous value (which can only happen once the
    // tracked value has itself left the legal ring).
    logic match;
    assign match = (bit_p1 == expected_next(prev, mode_r)) &&
                   (!mode_r || johnson_legal(bit_p1));

    logic [3:0] cnt_inc;
    assign cnt_inc = match_cnt + 4'd1;

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_r;
        prev_nxt     = prev;
        cnt_nxt      = match_cnt;
        err_nxt      = err;
        err_cnt_nxt  = err_cnt;
        last_bad_nxt = last_bad;

        case (state)
            IDLE: begin
                mode_nxt = mode;
                if (sample_evt) begin
                    prev_nxt  = bit_p1;
                    cnt_nxt   = 4'd0;
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (sample_evt) begin
                    prev_nxt = bit_p1;
                    if (match) begin
                        if (cnt_inc == LOCK_TGT) begin
                            cnt_nxt   = 4'd0;
                            state_nxt = LOCKED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (sample_evt) begin
                    prev_nxt = bit_p1;
                    if (!match) begin
                        cnt_nxt      = 4'd0;
                        state_nxt    = TRACK;
                        err_nxt      = 1'b1;
                        err_cnt_nxt  = sat_inc(err_cnt);
                        last_bad_nxt = bit_p1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // clr overrides any error update in the same cycle but leaves the
        // FSM path untouched.
        if (clr) begin
            err_nxt      = 1'b0;
            err_cnt_nxt  = '0;
            last_bad_nxt = 4'd0;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_counter_seq_checker.sv
module tb_counter_seq_checker;

    localparam int LOCK  = 4;
    localparam int ERR_W = 8;
    localparam int ECMAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [3:0]       bit_in;
    logic             mode;
    logic             clr;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       last_bad;

    counter_seq_checker #(.LOCK_COUNT(LOCK), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .bit_in(bit_in), .mode(mode),
        .clr(clr), .locked(locked), .err(err), .err_cnt(err_cnt),
        .last_bad(last_bad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: Johnson ring as an ordered list of codes.
    int jc[8] = '{0, 1, 3, 7, 15, 14, 12, 8};
    int m_phase;   // 0 waiting for first sample, 1 tracking, 2 locked
    int m_mode, m_p, m_cnt, m_err, m_ecnt, m_lb;

    function automatic int jidx(input int v);
        for (int i = 0; i < 8; i++) if (jc[i] == v) return i;
        return -1;
    endfunction

    function automatic bit model_match(input int s);
        int idx;
        if (m_mode == 0) return s == ((m_p + 15) % 16);
        idx = jidx(m_p);
        return (idx >= 0) && (s == jc[(idx + 1) % 8]);
    endfunction

    function automatic int model_good_next();
        int idx;
        if (m_mode == 0) return (m_p + 15) % 16;
        idx = jidx(m_p);
        if (idx < 0) return jc[$urandom % 8];
        return jc[(idx + 1) % 8];
    endfunction

    function automatic logic [3:0] jshift(input logic [3:0] v);
        return ((v & 4'd7) << 1) | {3'b000, ~v[3]};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_p = 0; m_cnt = 0; m_err = 0; m_ecnt = 0; m_lb = 0;
    endtask

    task automatic model_sample(input int s, input bit with_clr);
        if (m_phase == 0) begin
            m_mode = mode; m_cnt = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (model_match(s)) m_cnt++; else m_cnt = 0;
            if (m_cnt == LOCK) begin m_phase = 2; m_cnt = 0; end
        end else if (!model_match(s)) begin
            m_err = 1; m_ecnt = (m_ecnt < ECMAX) ? m_ecnt + 1 : ECMAX;
            m_lb = s; m_cnt = 0; m_phase = 1;
        end
        m_p = s;
        if (with_clr) begin m_err = 0; m_ecnt = 0; m_lb = 0; end
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk({tag, ".locked"},   locked,   (m_phase == 2) ? 1 : 0);
        chk({tag, ".err"},      err,      m_err);
        chk({tag, ".err_cnt"},  err_cnt,  m_ecnt);
        chk({tag, ".last_bad"}, last_bad, m_lb);
    endtask

    // One tick period of the counter under test; optionally raises clr in
    // exactly the cycle where the sample event is evaluated.
    task automatic do_sample(input logic [3:0] v, input bit with_clr);
        @(posedge clk); #1;
        bit_in = v; tick = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (with_clr) clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_sample(v, with_clr);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_err = 0; m_ecnt = 0; m_lb = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0; tick = 1'b0; bit_in = 4'd0; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] val;
        int         locked;
        int         err;
        int         cnt;
        int         lb;
    } vec_t;

    vec_t       tbl[20];
    logic [3:0] nv;

    initial begin
        tbl[0]  = '{4'd5,  0, 0, 0, 0};
        tbl[1]  = '{4'd4,  0, 0, 0, 0};
        tbl[2]  = '{4'd3,  0, 0, 0, 0};
        tbl[3]  = '{4'd2,  0, 0, 0, 0};
        tbl[4]  = '{4'd1,  1, 0, 0, 0};
        tbl[5]  = '{4'd0,  1, 0, 0, 0};
        tbl[6]  = '{4'd15, 1, 0, 0, 0};
        tbl[7]  = '{4'd14, 1, 0, 0, 0};
        tbl[8]  = '{4'd13, 1, 0, 0, 0};
        tbl[9]  = '{4'd12, 1, 0, 0, 0};
        tbl[10] = '{4'd11, 1, 0, 0, 0};
        tbl[11] = '{4'd10, 1, 0, 0, 0};
        tbl[12] = '{4'd9,  1, 0, 0, 0};
        tbl[13] = '{4'd8,  1, 0, 0, 0};
        tbl[14] = '{4'd7,  1, 0, 0, 0};
        tbl[15] = '{4'd9,  0, 1, 1, 9};
        tbl[16] = '{4'd8,  0, 1, 1, 9};
        tbl[17] = '{4'd7,  0, 1, 1, 9};
        tbl[18] = '{4'd6,  0, 1, 1, 9};
        tbl[19] = '{4'd5,  1, 1, 1, 9};

        rst = 1'b0; tick = 1'b0; bit_in = 4'd0; mode = 1'b0; clr = 1'b0;
        m_mode = 0;
        model_reset();

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst.locked", locked, 0);
        chk("rst.err", err, 0);
        chk("rst.err_cnt", err_cnt, 0);
        chk("rst.last_bad", last_bad, 0);

        // Down-counter lock, wrap, mismatch and relock from a table
        for (int i = 0; i < 20; i++) begin
            do_sample(tbl[i].val, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d.locked", i), locked, tbl[i].locked);
            chk($sformatf("tbl%0d.err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d.err_cnt", i), err_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d.last_bad", i), last_bad, tbl[i].lb);
        end

        // clr alone: clears sticky outputs, keeps lock
        pulse_clr();
        check_all("clr_only");

        // Saturation: 300 locked mismatches, each followed by a relock
        for (int i = 0; i < 300; i++) begin
            nv = 4'(m_p + 7);
            do_sample(nv, 1'b0);
            for (int k = 0; k < LOCK; k++) do_sample(4'(m_p - 1), 1'b0);
            if (i == 100) check_all("sat_mid");
        end
        check_all("sat_end");
        chk("sat.err_cnt_255", err_cnt, 255);

        // clr in the same cycle as a locked mismatch
        do_sample(4'(m_p + 7), 1'b1);
        check_all("clr_mismatch");
        chk("clr_mismatch.unlocked", locked, 0);
        chk("clr_mismatch.cnt0", err_cnt, 0);

        // Johnson mode lock, then an illegal code
        mode = 1'b1;
        do_reset();
        do_sample(4'b0000, 1'b0);
        do_sample(4'b0001, 1'b0);
        do_sample(4'b0011, 1'b0);
        do_sample(4'b0111, 1'b0);
        do_sample(4'b1111, 1'b0);
        check_all("j_lock");
        do_sample(4'b1110, 1'b0);
        check_all("j_lock2");
        chk("j_lock2.locked", locked, 1);
        do_sample(4'b0101, 1'b0);
        check_all("j_bad");
        chk("j_bad.last_bad", last_bad, 5);

        // Illegal codes that equal the shifted previous value never lock
        nv = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            nv = jshift(nv);
            do_sample(nv, 1'b0);
        end
        check_all("j_illegal_chain");

        // Mode change while tracking is ignored
        mode = 1'b0;
        do_sample(4'b0000, 1'b0);
        do_sample(4'b0001, 1'b0);
        do_sample(4'b0011, 1'b0);
        do_sample(4'b0111, 1'b0);
        do_sample(4'b1111, 1'b0);
        check_all("j_mode_ignored");

        // Asynchronous reset between edges while locked
        @(posedge clk); #3 rst = 1'b0;
        #1;
        model_reset();
        chk("arst.locked", locked, 0);
        chk("arst.err", err, 0);
        chk("arst.err_cnt", err_cnt, 0);
        chk("arst.last_bad", last_bad, 0);
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mode = 1'b0;
        do_sample(4'd3, 1'b0);
        check_all("arst.first");
        for (int k = 0; k < LOCK; k++) do_sample(4'(m_p - 1), 1'b0);
        check_all("arst.relock");

        // Randomized run against the reference model
        mode = 1'($urandom % 2);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 30 == 0) mode = ~mode;
            if ($urandom % 20 == 0) begin
                pulse_clr();
            end else begin
                if (m_phase == 0 || ($urandom % 100) < 85)
                    nv = 4'(model_good_next());
                else
                    nv = 4'($urandom % 16);
                do_sample(nv, ($urandom % 25) == 0);
            end
            check_all($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
